// File: rtl/spi_protocol_pkg.sv
// spi_protocol_pkg
//   Shared constants for the SPI command decoder: opcode values, the
//   status magic byte, the memory address width, the decoder state
//   encoding and a saturating byte-increment helper.
package spi_protocol_pkg;

  localparam int unsigned MEM_ADDR_W = 24;

  localparam logic [7:0] OP_WRITE_REG   = 8'h01;
  localparam logic [7:0] OP_WRITE_MEM   = 8'h02;
  localparam logic [7:0] OP_READ_STATUS = 8'h03;

  localparam logic [7:0] STATUS_MAGIC   = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPCODE   = 3'd1,
    ST_REG_ADDR = 3'd2,
    ST_REG_DATA = 3'd3,
    ST_MEM_ADDR = 3'd4,
    ST_MEM_DATA = 3'd5,
    ST_STATUS   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  // Increment that sticks at 0xFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? 8'hFF : value + 8'd1;
  endfunction

endpackage

// File: rtl/spi_command_decoder.sv
// spi_command_decoder
//   Decodes framed SPI byte streams into register writes, memory burst
//   writes and a status read-back, and counts protocol errors.
//
// Ports
//   i_master_clk           in   1   master clock
//   i_master_reset_n       in   1   async active-low reset
//   i_master_data          in   8   received SPI byte
//   i_master_data_valid    in   1   strobe qualifying i_master_data
//   i_master_start         in   1   frame-start pulse (chip-select assert)
//   i_master_end           in   1   frame-end pulse (chip-select deassert)
//   o_response_data        out  8   next byte for the SPI controller to send
//   o_response_data_valid  out  1   strobe qualifying o_response_data
//   o_reg_wr_en            out  1   register-write strobe
//   o_reg_addr             out  8   register address
//   o_reg_data             out  8   register write data
//   o_mem_wr_en            out  1   memory-write strobe
//   o_mem_addr             out  24  memory byte address
//   o_mem_data             out  8   memory write data
//   o_error_count          out  8   saturating protocol error count
//
// States
//   state       | meaning
//   ------------+-----------------------------------------------------
//   IDLE        | outside a frame, bytes are discarded
//   OPCODE      | frame open, waiting for the opcode byte
//   REG_ADDR    | WRITE_REG, waiting for the register address
//   REG_DATA    | WRITE_REG, waiting for the register data
//   MEM_ADDR    | WRITE_MEM, collecting 3 address bytes MSB first
//   MEM_DATA    | WRITE_MEM, each byte is written then address advances
//   STATUS      | READ_STATUS, answering with error count then zeros
//   IGNORE      | rest of frame is discarded (done or unknown opcode)
module spi_command_decoder
  import spi_protocol_pkg::*;
(
  input  logic        i_master_clk,
  input  logic        i_master_reset_n,
  input  logic [7:0]  i_master_data,
  input  logic        i_master_data_valid,
  input  logic        i_master_start,
  input  logic        i_master_end,
  output logic [7:0]  o_response_data,
  output logic        o_response_data_valid,
  output logic        o_reg_wr_en,
  output logic [7:0]  o_reg_addr,
  output logic [7:0]  o_reg_data,
  output logic        o_mem_wr_en,
  output logic [23:0] o_mem_addr,
  output logic [7:0]  o_mem_data,
  output logic [7:0]  o_error_count
);

  state_e                  state_q, state_d;
  logic [1:0]              byte_idx_q, byte_idx_d;
  logic [7:0]              resp_data_q, resp_data_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    reg_wr_en_q, reg_wr_en_d;
  logic [7:0]              reg_addr_q, reg_addr_d;
  logic [7:0]              reg_data_q, reg_data_d;
  logic                    mem_wr_en_q, mem_wr_en_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]              mem_data_q, mem_data_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  // Working signals for the current cycle.
  state_e     frame_state;   // state the incoming byte is decoded in
  logic [1:0] frame_idx;
  state_e     post_state;    // state after the byte has been consumed
  state_e     closing_state; // state of the frame an end pulse closes
  logic       unknown_op;
  logic       incomplete;

  always_ff @(posedge i_master_clk or negedge i_master_reset_n) begin
    if (!i_master_reset_n) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 2'd0;
      resp_data_q  <= 8'h00;
      resp_valid_q <= 1'b0;
      reg_wr_en_q  <= 1'b0;
      reg_addr_q   <= 8'h00;
      reg_data_q   <= 8'h00;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= 8'h00;
      err_cnt_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      reg_wr_en_q  <= reg_wr_en_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  always_comb begin
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    reg_wr_en_d  = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    mem_wr_en_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    err_cnt_d    = err_cnt_q;
    unknown_op   = 1'b0;
    incomplete   = 1'b0;

    // The address advances the cycle after a write strobe so the strobe
    // cycle itself still shows the address being written.
    if (mem_wr_en_q) begin
      mem_addr_d = mem_addr_q + {{(MEM_ADDR_W-1){1'b0}}, 1'b1};
    end

    // A start pulse opens a new frame immediately, so a byte arriving in
    // the same cycle is that frame's opcode.
    frame_state = i_master_start ? ST_OPCODE : state_q;
    frame_idx   = i_master_start ? 2'd0 : byte_idx_q;
    post_state  = frame_state;
    byte_idx_d  = frame_idx;

    if (i_master_data_valid) begin
      case (frame_state)
        ST_OPCODE: begin
          byte_idx_d = 2'd0;
          case (i_master_data)
            OP_WRITE_REG:   post_state = ST_REG_ADDR;
            OP_WRITE_MEM:   post_state = ST_MEM_ADDR;
            OP_READ_STATUS: begin
              post_state   = ST_STATUS;
              resp_data_d  = STATUS_MAGIC;
              resp_valid_d = 1'b1;
            end
            default: begin
              post_state = ST_IGNORE;
              unknown_op = 1'b1;
            end
          endcase
        end
        ST_REG_ADDR: begin
          reg_addr_d = i_master_data;
          post_state = ST_REG_DATA;
        end
        ST_REG_DATA: begin
          reg_data_d  = i_master_data;
          reg_wr_en_d = 1'b1;
          post_state  = ST_IGNORE;
        end
        ST_MEM_ADDR: begin
          mem_addr_d = {mem_addr_q[MEM_ADDR_W-9:0], i_master_data};
          if (frame_idx == 2'd2) begin
            post_state = ST_MEM_DATA;
            byte_idx_d = 2'd0;
          end else begin
            byte_idx_d = frame_idx + 2'd1;
          end
        end
        ST_MEM_DATA: begin
          mem_data_d  = i_master_data;
          mem_wr_en_d = 1'b1;
        end
        ST_STATUS: begin
          resp_valid_d = 1'b1;
          if (frame_idx == 2'd0) begin
            resp_data_d = err_cnt_q;
            byte_idx_d  = 2'd1;
          end else begin
            resp_data_d = 8'h00;
          end
        end
        default: ;  // IDLE and IGNORE drop the byte
      endcase
    end

    // With start and end together the end closes the previous frame (in
    // its registered state) and the start opens the next one; otherwise
    // the end closes the frame after any coincident byte is consumed.
    closing_state = i_master_start ? state_q : post_state;
    if (i_master_end) begin
      incomplete = (closing_state == ST_REG_ADDR) ||
                   (closing_state == ST_REG_DATA) ||
                   (closing_state == ST_MEM_ADDR);
    end

    if (i_master_end && !i_master_start) begin
      state_d = ST_IDLE;
    end else begin
      state_d = post_state;
    end

    // Two simultaneous error causes still count as a single error.
    if (unknown_op || incomplete) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end
  end

  assign o_response_data       = resp_data_q;
  assign o_response_data_valid = resp_valid_q;
  assign o_reg_wr_en           = reg_wr_en_q;
  assign o_reg_addr            = reg_addr_q;
  assign o_reg_data            = reg_data_q;
  assign o_mem_wr_en           = mem_wr_en_q;
  assign o_mem_addr            = mem_addr_q;
  assign o_mem_data            = mem_data_q;
  assign o_error_count         = err_cnt_q;

endmodule

// File: tb/tb_spi_command_decoder.sv
module tb_spi_command_decoder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        start;
  logic        endp;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        mem_wr_en;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  err_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  spi_command_decoder dut (
    .i_master_clk          (clk),
    .i_master_reset_n      (rst_n),
    .i_master_data         (data),
    .i_master_data_valid   (valid),
    .i_master_start        (start),
    .i_master_end          (endp),
    .o_response_data       (resp_data),
    .o_response_data_valid (resp_valid),
    .o_reg_wr_en           (reg_wr_en),
    .o_reg_addr            (reg_addr),
    .o_reg_data            (reg_data),
    .o_mem_wr_en           (mem_wr_en),
    .o_mem_addr            (mem_addr),
    .o_mem_data            (mem_data),
    .o_error_count         (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs driven before the edge, outputs
  // expected just after it.
  typedef struct packed {
    logic        s;
    logic        e;
    logic        v;
    logic [7:0]  d;
    logic        rv;
    logic [7:0]  rd;
    logic        rw;
    logic [7:0]  ra;
    logic [7:0]  rdat;
    logic        mw;
    logic [23:0] ma;
    logic [7:0]  md;
    logic [7:0]  err;
  } vec_t;

  localparam int NVEC = 41;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic s, input logic e, input logic v,
                              input logic [7:0] d, input logic rv,
                              input logic [7:0] rd, input logic rw,
                              input logic [7:0] ra, input logic [7:0] rdat,
                              input logic mw, input logic [23:0] ma,
                              input logic [7:0] md, input logic [7:0] err);
    vec_t r;
    r.s = s; r.e = e; r.v = v; r.d = d;
    r.rv = rv; r.rd = rd; r.rw = rw; r.ra = ra; r.rdat = rdat;
    r.mw = mw; r.ma = ma; r.md = md; r.err = err;
    return r;
  endfunction

  function automatic logic [66:0] obs();
    return {resp_valid, resp_data, reg_wr_en, reg_addr, reg_data,
            mem_wr_en, mem_addr, mem_data, err_cnt};
  endfunction

  function automatic logic [66:0] exp_of(input vec_t r);
    return {r.rv, r.rd, r.rw, r.ra, r.rdat, r.mw, r.ma, r.md, r.err};
  endfunction

  task automatic check(input string name, input logic [66:0] act,
                       input logic [66:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step(input logic s, input logic e, input logic v,
                      input logic [7:0] d);
    @(negedge clk);
    start = s; endp = e; valid = v; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        bad;
    logic [66:0] zero;
    zero = '0;

    //                 s  e  v  d      rv rd     rw ra     rdat   mw ma          md     err
    tbl[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 0, 24'h000000, 8'h00, 8'h00);
    tbl[1]  = mk(0, 0, 1, 8'h01, 0, 8'h00, 0, 8'h00, 8'h00, 0, 24'h000000, 8'h00, 8'h00);
    tbl[2]  = mk(0, 0, 1, 8'h10, 0, 8'h00, 0, 8'h10, 8'h00, 0, 24'h000000, 8'h00, 8'h00);
    tbl[3]  = mk(0, 0, 1, 8'h5A, 0, 8'h00, 1, 8'h10, 8'h5A, 0, 24'h000000, 8'h00, 8'h00);
    tbl[4]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h10, 8'h5A, 0, 24'h000000, 8'h00, 8'h00);
    tbl[5]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h10, 8'h5A, 0, 24'h000000, 8'h00, 8'h00);
    tbl[6]  = mk(0, 0, 1, 8'h01, 0, 8'h00, 0, 8'h10, 8'h5A, 0, 24'h000000, 8'h00, 8'h00);
    tbl[7]  = mk(0, 0, 1, 8'h20, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h00);
    tbl[8]  = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h01);
    tbl[9]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h01);
    tbl[10] = mk(0, 0, 1, 8'h7E, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[11] = mk(0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[12] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[13] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[14] = mk(0, 0, 1, 8'h03, 1, 8'hA5, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[15] = mk(0, 0, 1, 8'h00, 1, 8'h02, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[16] = mk(0, 0, 1, 8'h00, 1, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[17] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[18] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[19] = mk(0, 0, 1, 8'h02, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000000, 8'h00, 8'h02);
    tbl[20] = mk(0, 0, 1, 8'hFF, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h0000FF, 8'h00, 8'h02);
    tbl[21] = mk(0, 0, 1, 8'hFF, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h00FFFF, 8'h00, 8'h02);
    tbl[22] = mk(0, 0, 1, 8'hFE, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'hFFFFFE, 8'h00, 8'h02);
    tbl[23] = mk(0, 0, 1, 8'h11, 0, 8'h00, 0, 8'h20, 8'h5A, 1, 24'hFFFFFE, 8'h11, 8'h02);
    tbl[24] = mk(0, 0, 1, 8'h22, 0, 8'h00, 0, 8'h20, 8'h5A, 1, 24'hFFFFFF, 8'h22, 8'h02);
    tbl[25] = mk(0, 0, 1, 8'h33, 0, 8'h00, 0, 8'h20, 8'h5A, 1, 24'h000000, 8'h33, 8'h02);
    tbl[26] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000001, 8'h33, 8'h02);
    tbl[27] = mk(0, 0, 1, 8'h55, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000001, 8'h33, 8'h02);
    tbl[28] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000001, 8'h33, 8'h02);
    tbl[29] = mk(0, 0, 1, 8'h01, 0, 8'h00, 0, 8'h20, 8'h5A, 0, 24'h000001, 8'h33, 8'h02);
    tbl[30] = mk(0, 0, 1, 8'h33, 0, 8'h00, 0, 8'h33, 8'h5A, 0, 24'h000001, 8'h33, 8'h02);
    tbl[31] = mk(0, 1, 1, 8'h44, 0, 8'h00, 1, 8'h33, 8'h44, 0, 24'h000001, 8'h33, 8'h02);
    tbl[32] = mk(1, 0, 1, 8'h01, 0, 8'h00, 0, 8'h33, 8'h44, 0, 24'h000001, 8'h33, 8'h02);
    tbl[33] = mk(0, 0, 1, 8'h66, 0, 8'h00, 0, 8'h66, 8'h44, 0, 24'h000001, 8'h33, 8'h02);
    tbl[34] = mk(0, 0, 1, 8'h77, 0, 8'h00, 1, 8'h66, 8'h77, 0, 24'h000001, 8'h33, 8'h02);
    tbl[35] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h66, 8'h77, 0, 24'h000001, 8'h33, 8'h02);
    tbl[36] = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h66, 8'h77, 0, 24'h000001, 8'h33, 8'h02);
    tbl[37] = mk(0, 0, 1, 8'h02, 0, 8'h00, 0, 8'h66, 8'h77, 0, 24'h000001, 8'h33, 8'h02);
    tbl[38] = mk(0, 0, 1, 8'hAB, 0, 8'h00, 0, 8'h66, 8'h77, 0, 24'h0001AB, 8'h33, 8'h02);
    tbl[39] = mk(1, 1, 1, 8'h7E, 0, 8'h00, 0, 8'h66, 8'h77, 0, 24'h0001AB, 8'h33, 8'h03);
    tbl[40] = mk(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h66, 8'h77, 0, 24'h0001AB, 8'h33, 8'h03);

    rst_n = 1'b0; start = 1'b0; endp = 1'b0; valid = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs(), zero);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].s, tbl[i].e, tbl[i].v, tbl[i].d);
      check($sformatf("vec%0d", i), obs(), exp_of(tbl[i]));
    end

    // Saturation: error count is 3 here; 251 more errors reach 0xFE,
    // the remaining 49 frames must stick at 0xFF.
    for (int f = 0; f < 300; f++) begin
      step(1, 0, 0, 8'h00);
      step(0, 0, 1, 8'h7E);
      step(0, 1, 0, 8'h00);
      if (f == 250) check("err_cnt_fe", {59'd0, err_cnt}, {59'd0, 8'hFE});
    end
    check("err_cnt_sat", {59'd0, err_cnt}, {59'd0, 8'hFF});

    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h03);
    check("status_magic", {58'd0, resp_valid, resp_data}, {58'd0, 1'b1, 8'hA5});
    step(0, 0, 1, 8'h00);
    check("status_sat_cnt", {58'd0, resp_valid, resp_data}, {58'd0, 1'b1, 8'hFF});
    step(0, 1, 0, 8'h00);

    // Reset in the middle of a memory burst.
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'h02);
    step(0, 0, 1, 8'h12);
    step(0, 0, 1, 8'h34);
    step(0, 0, 1, 8'h56);
    step(0, 0, 1, 8'h99);
    check("burst_pre_reset", {mem_wr_en, mem_addr, mem_data},
          {1'b1, 24'h123456, 8'h99});
    @(negedge clk);
    rst_n = 1'b0; valid = 1'b1; data = 8'hAA;
    #1;
    check("reset_async", obs(), zero);
    @(posedge clk);
    #1;
    check("reset_held", obs(), zero);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 1, 8'hCC);
      if (obs() !== zero) bad = 1'b1;
    end
    check("post_reset_quiet", {66'd0, bad}, 67'd0);

    step(1, 0, 1, 8'h01);
    step(0, 0, 1, 8'h10);
    step(0, 0, 1, 8'h5A);
    check("start_valid_collision", obs(),
          {1'b0, 8'h00, 1'b1, 8'h10, 8'h5A, 1'b0, 24'h000000, 8'h00, 8'h00});
    step(0, 1, 0, 8'h00);
    check("collision_frame_close", obs(),
          {1'b0, 8'h00, 1'b0, 8'h10, 8'h5A, 1'b0, 24'h000000, 8'h00, 8'h00});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
